// File: rtl/hazard_scoreboard_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the decode hazard scoreboard: default widths,
// FSM state encoding and the bubble instruction encoding.
package hazard_scoreboard_pkg;

  localparam int REG_INDEX_BITS_DEF = 4;
  localparam int PEND_BITS_DEF      = 2;
  localparam int CNT_BITS_DEF       = 32;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  // Encoding the pipeline uses to mark a decode/EX slot as a bubble.
  localparam logic [31:0] DEAD_INSTR = 32'h0000_4033;

endpackage

// File: rtl/hazard_scoreboard_if.sv
`timescale 1ns/1ps
// Decode/Execute/WriteBack status into the scoreboard and the
// stall/flush/issue controls and debug counters back out.
interface hazard_scoreboard_if #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int CNT_BITS            = 32
);
  logic                           dec_valid;
  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src1_addr;
  logic [REG_INDEX_BIT_WIDTH-1:0] dec_src2_addr;
  logic                           dec_use_src1;
  logic                           dec_use_src2;
  logic                           dec_wr_reg;
  logic [REG_INDEX_BIT_WIDTH-1:0] dec_dest_addr;
  logic                           ex_redirect;
  logic                           wb_wr_reg;
  logic [REG_INDEX_BIT_WIDTH-1:0] wb_reg_addr;

  logic                stall;
  logic                flush_dec;
  logic                flush_ex;
  logic                issue;
  logic                busy;
  logic                err_underflow;
  logic [CNT_BITS-1:0] stall_cnt;
  logic [CNT_BITS-1:0] flush_cnt;

  modport master (
    output dec_valid, dec_src1_addr, dec_src2_addr, dec_use_src1, dec_use_src2,
           dec_wr_reg, dec_dest_addr, ex_redirect, wb_wr_reg, wb_reg_addr,
    input  stall, flush_dec, flush_ex, issue, busy, err_underflow,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  dec_valid, dec_src1_addr, dec_src2_addr, dec_use_src1, dec_use_src2,
           dec_wr_reg, dec_dest_addr, ex_redirect, wb_wr_reg, wb_reg_addr,
    output stall, flush_dec, flush_ex, issue, busy, err_underflow,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_sat_counter.sv
`timescale 1ns/1ps
// Saturating up-counter with enable; holds at all-ones once reached.
module sat_counter #(
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  output logic [CNT_BITS-1:0] cnt_o
);
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
`timescale 1ns/1ps
// Decode-stage hazard scoreboard: per-register in-flight writer counts,
// RAW/WAW stall, one-cycle squash after an Execute redirect, debug counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_INDEX_BIT_WIDTH = REG_INDEX_BITS_DEF,
  parameter int PEND_BITS           = PEND_BITS_DEF,
  parameter int CNT_BITS            = CNT_BITS_DEF
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave bus
);
  localparam int NREGS = 2 ** REG_INDEX_BIT_WIDTH;
  localparam logic [PEND_BITS-1:0] PEND_MAX = '1;

  logic [PEND_BITS-1:0] pend [NREGS];
  logic [NREGS-1:0]     pend_nz;
  logic [NREGS-1:0]     underflow;

  state_e state_q, state_d;
  logic   err_q, err_d;
  logic   hazard;
  logic   stall_raw, issue_raw;
  logic   stall, issue;

  // Each register tracks writers between issue and WB commit.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
    logic [PEND_BITS-1:0] cnt_q, cnt_d;
    logic                 inc, dec, udf;

    assign inc = issue && bus.dec_wr_reg &&
                 (bus.dec_dest_addr == REG_INDEX_BIT_WIDTH'(gi));
    assign dec = bus.wb_wr_reg && (bus.wb_reg_addr == REG_INDEX_BIT_WIDTH'(gi));

    always_comb begin
      cnt_d = cnt_q;
      udf   = 1'b0;
      if (inc && !dec) begin
        cnt_d = cnt_q + 1'b1;
      end else if (dec && !inc) begin
        if (cnt_q == '0) begin
          udf = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign pend[gi]      = cnt_q;
    assign pend_nz[gi]   = |cnt_q;
    assign underflow[gi] = udf;
  end

  // A register retiring this cycle is still pending: the RF write lands at the edge.
  assign hazard = bus.dec_valid &&
                  ((bus.dec_use_src1 && (pend[bus.dec_src1_addr] != '0)) ||
                   (bus.dec_use_src2 && (pend[bus.dec_src2_addr] != '0)) ||
                   (bus.dec_wr_reg   && (pend[bus.dec_dest_addr] == PEND_MAX)));

  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    issue_raw = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall_raw = hazard && !bus.ex_redirect;
        issue_raw = bus.dec_valid && !hazard && !bus.ex_redirect;
        if (bus.ex_redirect) begin
          state_d = ST_SQUASH;
        end
      end
      ST_SQUASH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign err_d = err_q | (|underflow);

  // Controls are forced low while reset is held, whatever decode presents.
  assign stall = reset & stall_raw;
  assign issue = reset & issue_raw;

  assign bus.stall         = stall;
  assign bus.issue         = issue;
  assign bus.flush_dec     = reset & bus.ex_redirect;
  assign bus.flush_ex      = reset & bus.ex_redirect;
  assign bus.busy          = |pend_nz;
  assign bus.err_underflow = err_q;

  sat_counter #(.CNT_BITS(CNT_BITS)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (stall),
    .cnt_o (bus.stall_cnt)
  );

  sat_counter #(.CNT_BITS(CNT_BITS)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (bus.flush_ex),
    .cnt_o (bus.flush_cnt)
  );
endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
// Bench for hazard_scoreboard: directed vector table, hand-written corner
// sequences, and a randomized run against a per-register count model.
module tb_hazard_scoreboard;
  localparam int RW = 4;
  localparam int CB = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_INDEX_BIT_WIDTH(RW), .CNT_BITS(CB)) bus ();

  hazard_scoreboard #(.REG_INDEX_BIT_WIDTH(RW), .PEND_BITS(2), .CNT_BITS(CB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic       sc_en = 1'b0;
  logic [2:0] sc_val;
  sat_counter #(.CNT_BITS(3)) u_sc (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (sc_en),
    .cnt_o (sc_val)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit rst; bit v; logic [3:0] s1; logic [3:0] s2; bit u1; bit u2;
    bit w; logic [3:0] d; bit rd; bit wbw; logic [3:0] wba;
    bit e_stall; bit e_issue; bit e_flush; bit e_busy; int e_scnt; int e_fcnt;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mkv(int rst, int v, int s1, int s2, int u1, int u2, int w, int d,
                               int rd, int wbw, int wba, int es, int ei, int ef, int eb,
                               int escnt, int efcnt);
    vec_t r;
    r.rst = (rst != 0); r.v = (v != 0); r.s1 = 4'(s1); r.s2 = 4'(s2);
    r.u1 = (u1 != 0); r.u2 = (u2 != 0); r.w = (w != 0); r.d = 4'(d);
    r.rd = (rd != 0); r.wbw = (wbw != 0); r.wba = 4'(wba);
    r.e_stall = (es != 0); r.e_issue = (ei != 0); r.e_flush = (ef != 0); r.e_busy = (eb != 0);
    r.e_scnt = escnt; r.e_fcnt = efcnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic apply(input bit v, input logic [3:0] s1, input logic [3:0] s2, input bit u1,
                       input bit u2, input bit w, input logic [3:0] d, input bit rd,
                       input bit wbw, input logic [3:0] wba);
    bus.dec_valid = v; bus.dec_src1_addr = s1; bus.dec_src2_addr = s2;
    bus.dec_use_src1 = u1; bus.dec_use_src2 = u2; bus.dec_wr_reg = w;
    bus.dec_dest_addr = d; bus.ex_redirect = rd; bus.wb_wr_reg = wbw; bus.wb_reg_addr = wba;
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int pm [16];
    bit sq, errm;
    longint scm, fcm;
    bit v, u1, u2, w, rd, wbw, hz, e_stall, e_issue, e_busy, inc, dec;
    logic [3:0] s1, s2, d, wba;
    int r;

    idle();
    @(negedge clk);
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err_underflow, 0);
    chk("rst_scnt", bus.stall_cnt, 0);
    chk("rst_fcnt", bus.flush_cnt, 0);

    // Independent stream, then RAW latency and redirect-during-stall.
    tbl[0]  = mkv(1,1,5,0,1,0,1,1, 0,0,0, 0,1,0,0, 0,0);
    tbl[1]  = mkv(0,1,6,0,1,0,1,2, 0,0,0, 0,1,0,1, 0,0);
    tbl[2]  = mkv(0,1,7,0,1,0,1,3, 0,0,0, 0,1,0,1, 0,0);
    tbl[3]  = mkv(0,1,8,0,1,0,1,4, 0,0,0, 0,1,0,1, 0,0);
    tbl[4]  = mkv(1,1,0,0,0,0,1,3, 0,0,0, 0,1,0,0, 0,0);
    tbl[5]  = mkv(0,1,3,0,1,0,0,0, 0,0,0, 1,0,0,1, 0,0);
    tbl[6]  = mkv(0,1,3,0,1,0,0,0, 0,0,0, 1,0,0,1, 1,0);
    tbl[7]  = mkv(0,1,3,0,1,0,0,0, 0,1,3, 1,0,0,1, 2,0);
    tbl[8]  = mkv(0,1,3,0,1,0,0,0, 0,0,0, 0,1,0,0, 3,0);
    tbl[9]  = mkv(0,1,0,0,0,0,1,3, 0,0,0, 0,1,0,0, 3,0);
    tbl[10] = mkv(0,1,3,0,1,0,1,3, 0,0,0, 1,0,0,1, 3,0);
    tbl[11] = mkv(0,1,3,0,1,0,1,3, 1,0,0, 0,0,1,1, 4,0);
    tbl[12] = mkv(0,1,3,0,1,0,1,3, 0,0,0, 0,0,0,1, 4,1);
    tbl[13] = mkv(0,1,0,3,0,1,1,3, 0,0,0, 1,0,0,1, 4,1);
    tbl[14] = mkv(0,0,0,0,0,0,0,0, 0,1,3, 0,0,0,1, 5,1);
    tbl[15] = mkv(0,1,3,0,1,0,0,0, 0,0,0, 0,1,0,0, 5,1);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].u1, tbl[i].u2, tbl[i].w, tbl[i].d,
            tbl[i].rd, tbl[i].wbw, tbl[i].wba);
      chk($sformatf("vec%0d_stall", i), bus.stall, tbl[i].e_stall);
      chk($sformatf("vec%0d_issue", i), bus.issue, tbl[i].e_issue);
      chk($sformatf("vec%0d_flush_dec", i), bus.flush_dec, tbl[i].e_flush);
      chk($sformatf("vec%0d_flush_ex", i), bus.flush_ex, tbl[i].e_flush);
      chk($sformatf("vec%0d_busy", i), bus.busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_scnt", i), bus.stall_cnt, 64'(tbl[i].e_scnt));
      chk($sformatf("vec%0d_fcnt", i), bus.flush_cnt, 64'(tbl[i].e_fcnt));
      $display("vec %0d: stall=%b issue=%b flush=%b busy=%b scnt=%0d fcnt=%0d",
               i, bus.stall, bus.issue, bus.flush_ex, bus.busy, bus.stall_cnt, bus.flush_cnt);
      @(negedge clk);
    end

    // WAW saturation on r2.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      apply(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      chk($sformatf("waw_issue%0d", k), bus.issue, 1);
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      apply(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      chk($sformatf("waw_stall%0d", k), bus.stall, 1);
      @(negedge clk);
    end
    apply(1, 0, 0, 0, 0, 1, 2, 0, 1, 2);
    chk("waw_stall_at_retire", bus.stall, 1);
    @(negedge clk);
    apply(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    chk("waw_issue_after", bus.issue, 1);
    $display("waw: issue=%b stall=%b scnt=%0d", bus.issue, bus.stall, bus.stall_cnt);
    @(negedge clk);

    // Simultaneous issue+retire on r7, then underflow on r9.
    do_reset();
    apply(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    chk("sim_issue0", bus.issue, 1);
    @(negedge clk);
    apply(1, 0, 0, 0, 0, 1, 7, 0, 1, 7);
    chk("sim_issue1", bus.issue, 1);
    @(negedge clk);
    apply(1, 7, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("sim_pend_held", bus.stall, 1);
    @(negedge clk);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    @(negedge clk);
    idle();
    chk("sim_drained", bus.busy, 0);
    chk("sim_no_err", bus.err_underflow, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    @(negedge clk);
    idle();
    chk("udf_err", bus.err_underflow, 1);
    chk("udf_busy", bus.busy, 0);
    @(negedge clk);
    chk("udf_sticky", bus.err_underflow, 1);
    $display("udf: err=%b busy=%b", bus.err_underflow, bus.busy);

    // Asynchronous reset in the middle of a stall run.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      apply(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      apply(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
    end
    apply(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("ar_pre_scnt", bus.stall_cnt, 5);
    chk("ar_pre_stall", bus.stall, 1);
    #1;
    bus.ex_redirect = 1'b1;
    bus.dec_use_src1 = 1'b0;
    reset = 1'b0;
    #1;
    chk("ar_stall", bus.stall, 0);
    chk("ar_issue", bus.issue, 0);
    chk("ar_flush_dec", bus.flush_dec, 0);
    chk("ar_flush_ex", bus.flush_ex, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_scnt", bus.stall_cnt, 0);
    chk("ar_fcnt", bus.flush_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    apply(1, 1, 0, 1, 0, 1, 1, 0, 0, 0);
    chk("ar_run_issue", bus.issue, 1);
    $display("async reset: issue=%b busy=%b scnt=%0d", bus.issue, bus.busy, bus.stall_cnt);
    @(negedge clk);

    // Narrow saturating counter holds at all-ones.
    do_reset();
    sc_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("sat_mid", sc_val, 3);
    repeat (7) @(negedge clk);
    chk("sat_top", sc_val, 7);
    sc_en = 1'b0;
    $display("sat: val=%0d", sc_val);

    // Randomized run against the count model.
    do_reset();
    foreach (pm[i]) pm[i] = 0;
    sq = 0; errm = 0; scm = 0; fcm = 0;
    for (int n = 0; n < 800; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      s1 = 4'($urandom_range(0, 3));
      s2 = 4'($urandom_range(0, 3));
      u1 = 1'($urandom_range(0, 1));
      u2 = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      d  = 4'($urandom_range(0, 3));
      rd = !sq && ($urandom_range(0, 9) == 0);
      r  = $urandom_range(0, 3);
      wba = 4'(r);
      wbw = ($urandom_range(0, 2) != 0) && ((pm[r] > 0) || ($urandom_range(0, 15) == 0));
      apply(v, s1, s2, u1, u2, w, d, rd, wbw, wba);

      hz = v && ((u1 && pm[s1] != 0) || (u2 && pm[s2] != 0) || (w && pm[d] == 3));
      e_stall = !sq && hz && !rd;
      e_issue = !sq && v && !hz && !rd;
      e_busy = 0;
      foreach (pm[i]) if (pm[i] != 0) e_busy = 1;

      chk($sformatf("rnd%0d_stall", n), bus.stall, e_stall);
      chk($sformatf("rnd%0d_issue", n), bus.issue, e_issue);
      chk($sformatf("rnd%0d_flush_dec", n), bus.flush_dec, rd);
      chk($sformatf("rnd%0d_flush_ex", n), bus.flush_ex, rd);
      chk($sformatf("rnd%0d_busy", n), bus.busy, e_busy);
      chk($sformatf("rnd%0d_err", n), bus.err_underflow, errm);
      chk($sformatf("rnd%0d_scnt", n), bus.stall_cnt, scm);
      chk($sformatf("rnd%0d_fcnt", n), bus.flush_cnt, fcm);
      $display("rnd %0d: v=%b rd=%b wb=%b/%0d stall=%b issue=%b busy=%b",
               n, v, rd, wbw, wba, bus.stall, bus.issue, bus.busy);

      for (int i = 0; i < 16; i++) begin
        inc = e_issue && w && (d == 4'(i));
        dec = wbw && (wba == 4'(i));
        if (inc && !dec) pm[i]++;
        else if (dec && !inc) begin
          if (pm[i] == 0) errm = 1;
          else pm[i]--;
        end
      end
      if (e_stall) scm++;
      if (rd) fcm++;
      sq = !sq && rd;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Pipeline hazard controller for the 5-stage processor (Fetch, Decode, Execute, Mem, WriteBack). It keeps a per-register count of in-flight writers and raises decode stall on read-after-write hazards and write-after-write saturation. It sequences squashes after an Execute-stage PC redirect. It counts stall and flush cycles for MMIO debug readout. It replaces the inline stall equation with a registered, instruction-accurate scoreboard.

Parameters:
REG_INDEX_BIT_WIDTH, 4, register index width; NREGS = 2**REG_INDEX_BIT_WIDTH
PEND_BITS, 2, width of each pending counter; PEND_MAX = 2**PEND_BITS-1 (3 = EX+MEM+WB)
CNT_BITS, 32, width of the performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; clears all state
dec_valid  in  1  decode holds a real instruction (not DEAD/bubble)
dec_src1_addr  in  REG_INDEX_BIT_WIDTH  decode source 1 index
dec_src2_addr  in  REG_INDEX_BIT_WIDTH  decode source 2 index
dec_use_src1  in  1  source 1 actually read
dec_use_src2  in  1  source 2 actually read
dec_wr_reg  in  1  decode instruction writes a register
dec_dest_addr  in  REG_INDEX_BIT_WIDTH  decode destination index
ex_redirect  in  1  Execute stage takes a branch/jump (pc_sel)
wb_wr_reg  in  1  WriteBack commits a register write this cycle
wb_reg_addr  in  REG_INDEX_BIT_WIDTH  WriteBack destination index
stall  out  1  hold PC and decode register, inject bubble into EX
flush_dec  out  1  replace the decode register with DEAD
flush_ex  out  1  inject bubble into EX (NOP op, wr_reg=0, wr_mem=0)
issue  out  1  decode instruction advances into EX this cycle
busy  out  1  any pending counter non-zero
err_underflow  out  1  sticky: retire seen with pending count 0
stall_cnt  out  CNT_BITS  saturating count of stall cycles
flush_cnt  out  CNT_BITS  saturating count of redirects

Behaviour:
- Reset (reset=0, asynchronous): all pending counters 0, FSM=RUN, counters 0, err_underflow 0. With reset asserted, stall/flush_dec/flush_ex/issue/busy are all 0.
- hazard (combinational) = dec_valid && ((dec_use_src1 && pend[src1]!=0) || (dec_use_src2 && pend[src2]!=0) || (dec_wr_reg && pend[dest]==PEND_MAX)).
- A register retiring this cycle still counts as pending, because the register file write lands at the clock edge. The hazard clears the cycle after the WB commit.
- FSM states:
  - RUN: stall = hazard && !ex_redirect. issue = dec_valid && !hazard && !ex_redirect.
  - RUN -> SQUASH on ex_redirect.
  - SQUASH (1 cycle): the decode register holds a bubble and fetch refills. issue=0, stall=0. Returns to RUN. A redirect in SQUASH is ignored; it cannot occur legally.
- flush_dec = flush_ex = ex_redirect (in both states). Redirect has priority over stall.
- Counter update each edge:
  - pend[dest] += 1 when issue && dec_wr_reg.
  - pend[wb_reg_addr] -= 1 when wb_wr_reg.
  - Same index in the same cycle: net unchanged.
  - Decrement at 0: counter stays 0 and err_underflow sets (sticky until reset).
  - Increment past PEND_MAX is impossible, because the WAW term stalls first.
- stall_cnt += 1 each cycle stall=1; flush_cnt += 1 each cycle ex_redirect=1. Both saturate at all-ones.
- busy = OR of all pend != 0 (combinational from registers).
- Latency:
  - Back-to-back RAW on an ALU result stalls exactly 3 cycles (writer in EX, MEM, WB).
  - One intervening instruction gives 2 stall cycles.

Decomposition:
- Shared package (Processor.vh):
  - PEND_BITS default
  - FSM state encodings ST_RUN=1'b0, ST_SQUASH=1'b1
  - the DEAD instruction constant
- Natural sub-module: sat_counter (CNT_BITS wide, enable, saturating, async active-low clear), instantiated for stall_cnt and flush_cnt.
- Pending array and FSM stay in hazard_scoreboard.

Test Plan:
- Independent stream: 4 valid instructions writing r1..r4, reading r5..r8 with no pending -> issue=1 every cycle, stall=0, stall_cnt=0.
- RAW: cycle0 issue writes r3 -> pend[r3]=1. Cycle1 decode reads r3 -> stall=1 for cycles 1-3. WB retire r3 at cycle3 -> issue=1 at cycle4, stall_cnt=3.
- Redirect during stall: r3 hazard pending, ex_redirect=1 -> stall=0, flush_dec=flush_ex=1, issue=0. Next cycle SQUASH with issue=0, then RUN. flush_cnt=1, pend[r3] not incremented.
- WAW saturation: three issues writing r2 with no retire -> pend[r2]=3. Fourth writer of r2 stalls until a WB retire of r2, then issues the following cycle.
- Simultaneous issue and retire of r7 with pend[r7]=1 -> pend[r7] stays 1. Retire of r9 with pend=0 -> err_underflow=1, pend[r9]=0.
- Reset mid-operation: pend[r1]=2, stall_cnt=5, drive reset=0 asynchronously -> all outputs and counters 0 immediately, busy=0, FSM=RUN after release.
